// File: rtl/modulator_pwm_param.sv
// -----------------------------------------------------------------------------
// modulator_pwm_param
//
// PWM amplitude modulator. Pulls W-bit samples from a first-word-fall-through
// FIFO and emits one PWM symbol per sample. The high time of a symbol is
// proportional to the sample value.
//
// A one-entry prefetch slot (next_q/next_valid_q) is refilled while the
// current symbol is running, so consecutive symbols follow each other with no
// idle cycle. When the prefetch slot is empty at the end of a symbol the
// sticky underrun flag is raised. The modulator then either goes idle
// (UNDERRUN_MODE=0) or repeats the last sample (UNDERRUN_MODE=1).
//
// Parameters
//   BITS_PER_SAMPLE   sample width W (2..16)
//   CLKS_PER_STEP     clk cycles per PWM step (>=1)
//   STEPS_PER_SYMBOL  PWM steps per symbol (2..2^W)
//   UNDERRUN_MODE     0: idle with pwm=0 on underrun, 1: repeat last sample
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active high
//   enable        1: run, 0: freeze all state
//   sample        FIFO head data, valid while empty=0
//   empty         FIFO empty
//   read          FIFO pop (combinational)
//   clr_underrun  clears the sticky underrun flag
//   pwm           modulated output, registered
//   symb_clk      1-cycle pulse on the first cycle of each symbol
//   busy          1 while a symbol is being transmitted
//   underrun      sticky underrun flag
// -----------------------------------------------------------------------------
module modulator_pwm_param #(
    parameter int BITS_PER_SAMPLE  = 8,
    parameter int CLKS_PER_STEP    = 1,
    parameter int STEPS_PER_SYMBOL = 255,
    parameter int UNDERRUN_MODE    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [BITS_PER_SAMPLE-1:0] sample,
    input  logic                       empty,
    output logic                       read,
    input  logic                       clr_underrun,
    output logic                       pwm,
    output logic                       symb_clk,
    output logic                       busy,
    output logic                       underrun
);

    localparam int W      = BITS_PER_SAMPLE;
    // A single-cycle step still needs a 1-bit counter to keep the logic uniform.
    localparam int STEP_W = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
    localparam int DUTY_W = $clog2(STEPS_PER_SYMBOL);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CLKS_PER_STEP - 1);
    localparam logic [DUTY_W-1:0] DUTY_LAST = DUTY_W'(STEPS_PER_SYMBOL - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        cur_q, cur_d;
    logic [W-1:0]        next_q, next_d;
    logic                next_valid_q, next_valid_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [DUTY_W-1:0]   duty_cnt_q, duty_cnt_d;
    logic                pwm_q, pwm_d;
    logic                symb_clk_q, symb_clk_d;
    logic                underrun_q, underrun_d;

    logic                step_tick;
    logic                sym_end;
    logic                load_now;
    logic                underrun_set;

    // -------------------------------------------------------------------------
    // Symbol timing events
    // -------------------------------------------------------------------------
    always_comb begin
        step_tick = (step_cnt_q == STEP_LAST);
        sym_end   = step_tick && (duty_cnt_q == DUTY_LAST);
        load_now  = ((state_q == ST_IDLE) && next_valid_q) ||
                    ((state_q == ST_RUN) && sym_end && next_valid_q);
    end

    // Pop whenever the prefetch slot is free or is being consumed this cycle.
    // Held low during reset so no FIFO entry is lost into a discarded slot.
    assign read = !rst && enable && !empty && (!next_valid_q || load_now);

    // -------------------------------------------------------------------------
    // State register (all flops)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            next_q       <= '0;
            next_valid_q <= 1'b0;
            step_cnt_q   <= '0;
            duty_cnt_q   <= '0;
            pwm_q        <= 1'b0;
            symb_clk_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            next_q       <= next_d;
            next_valid_q <= next_valid_d;
            step_cnt_q   <= step_cnt_d;
            duty_cnt_q   <= duty_cnt_d;
            pwm_q        <= pwm_d;
            symb_clk_q   <= symb_clk_d;
            underrun_q   <= underrun_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (next_valid_q) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sym_end && !next_valid_q && (UNDERRUN_MODE == 0)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        cur_d        = cur_q;
        next_d       = next_q;
        next_valid_d = next_valid_q;
        step_cnt_d   = step_cnt_q;
        duty_cnt_d   = duty_cnt_q;
        pwm_d        = pwm_q;
        symb_clk_d   = 1'b0;
        underrun_set = 1'b0;

        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    pwm_d = 1'b0;
                    if (next_valid_q) begin
                        cur_d      = next_q;
                        step_cnt_d = '0;
                        duty_cnt_d = '0;
                        symb_clk_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Compare against the pre-update counters, so pwm trails
                    // the counters by one cycle.
                    pwm_d = (W'(duty_cnt_q) < cur_q);
                    if (sym_end) begin
                        step_cnt_d = '0;
                        duty_cnt_d = '0;
                        if (next_valid_q) begin
                            cur_d      = next_q;
                            symb_clk_d = 1'b1;
                        end else begin
                            underrun_set = 1'b1;
                            // Repeat mode keeps cur_q and starts a fresh symbol.
                            if (UNDERRUN_MODE != 0) begin
                                symb_clk_d = 1'b1;
                            end
                        end
                    end else if (step_tick) begin
                        step_cnt_d = '0;
                        duty_cnt_d = duty_cnt_q + 1'b1;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                default: begin
                    pwm_d = 1'b0;
                end
            endcase

            // A refill takes priority over the consume that happens in the
            // same cycle: the slot stays valid with the new sample.
            if (read) begin
                next_d       = sample;
                next_valid_d = 1'b1;
            end else if (load_now) begin
                next_valid_d = 1'b0;
            end
        end

        // Set wins over a simultaneous clear.
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    assign pwm      = pwm_q;
    assign symb_clk = symb_clk_q;
    assign busy     = (state_q == ST_RUN);
    assign underrun = underrun_q;

endmodule

// File: tb/tb_modulator_pwm_param.sv
// -----------------------------------------------------------------------------
// tb_modulator_pwm_param
//
// Two modulators (W=4, 2 clks/step, 15 steps/symbol), one per underrun mode,
// each fed from its own FIFO model, plus one default-parameter instance.
// A symbol-level scoreboard pairs each symb_clk pulse with the sample it must
// carry (the next popped FIFO value, or the previous one on a repeat) and
// checks symbol length, high time, busy and the sticky underrun flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_modulator_pwm_param;

    localparam int W       = 4;
    localparam int CPS     = 2;
    localparam int STEPS   = 15;
    localparam int SYM_LEN = CPS * STEPS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         enable;
    logic         clr_underrun;
    logic [W-1:0] sample_a [2];
    logic [1:0]   empty_v;
    wire  [1:0]   read_v;
    wire  [1:0]   pwm_v;
    wire  [1:0]   symb_v;
    wire  [1:0]   busy_v;
    wire  [1:0]   underrun_v;

    logic [7:0]   def_sample;
    logic         def_empty;
    wire          def_read;
    wire          def_pwm;
    wire          def_symb;
    wire          def_busy;
    wire          def_underrun;

    modulator_pwm_param #(
        .BITS_PER_SAMPLE(W), .CLKS_PER_STEP(CPS), .STEPS_PER_SYMBOL(STEPS), .UNDERRUN_MODE(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .sample(sample_a[0]), .empty(empty_v[0]),
        .read(read_v[0]), .clr_underrun(clr_underrun), .pwm(pwm_v[0]), .symb_clk(symb_v[0]),
        .busy(busy_v[0]), .underrun(underrun_v[0])
    );

    modulator_pwm_param #(
        .BITS_PER_SAMPLE(W), .CLKS_PER_STEP(CPS), .STEPS_PER_SYMBOL(STEPS), .UNDERRUN_MODE(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .sample(sample_a[1]), .empty(empty_v[1]),
        .read(read_v[1]), .clr_underrun(clr_underrun), .pwm(pwm_v[1]), .symb_clk(symb_v[1]),
        .busy(busy_v[1]), .underrun(underrun_v[1])
    );

    modulator_pwm_param u_dut_def (
        .clk(clk), .rst(rst), .enable(enable), .sample(def_sample), .empty(def_empty),
        .read(def_read), .clr_underrun(clr_underrun), .pwm(def_pwm), .symb_clk(def_symb),
        .busy(def_busy), .underrun(def_underrun)
    );

    // Values applied at the next clock edge + 1
    logic nx_rst, nx_enable, nx_clr, nx_def_empty;

    // FIFO models and scoreboard state, index 0 = idle mode, 1 = repeat mode
    int fifo_buf [2][16];
    int fifo_n   [2];
    int pend_buf [2][4];
    int pend_n   [2];
    bit pop_pv   [2];
    int pop_val  [2];
    bit sym_active [2];
    int sym_val  [2];
    int sym_len  [2];
    int sym_high [2];
    int last_val [2];
    bit have_last [2];
    bit busy_prev [2];
    bit exp_ur   [2];
    int sym_count [2];
    int last_symb_cyc [2];
    int sym_dist [2];
    int rd_count [2];

    bit en_prev, rst_prev, clr_prev;
    int cyc;
    int tests_run;
    int tests_failed;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int v);
        if (fifo_n[d] < 16) begin
            fifo_buf[d][fifo_n[d]] = v;
            fifo_n[d]++;
        end
    endtask

    // Scoreboard update for one modulator, called mid-cycle.
    task automatic monitor(input int d);
        bit set_ev;
        int v;
        int exp_high;
        set_ev = 1'b0;
        v = 0;
        if (rst_prev) begin
            check("rst_pwm", int'(pwm_v[d]), 0);
            check("rst_symb_clk", int'(symb_v[d]), 0);
            check("rst_busy", int'(busy_v[d]), 0);
            check("rst_underrun", int'(underrun_v[d]), 0);
            sym_active[d] = 1'b0;
            pend_n[d]     = 0;
            exp_ur[d]     = 1'b0;
            have_last[d]  = 1'b0;
        end else begin
            if (sym_active[d]) begin
                // pwm of this cycle reflects the previous cycle's step
                if (en_prev) sym_high[d] += int'(pwm_v[d]);
                if (symb_v[d] || (busy_prev[d] && !busy_v[d])) begin
                    exp_high = ((sym_val[d] < STEPS) ? sym_val[d] : STEPS) * CPS;
                    check("sym_len", sym_len[d], SYM_LEN);
                    check("sym_high", sym_high[d], exp_high);
                    $display("[TB] dut%0d symbol sample=%0d high=%0d len=%0d", d, sym_val[d],
                             sym_high[d], sym_len[d]);
                    sym_active[d] = 1'b0;
                    if (!symb_v[d]) set_ev = 1'b1;
                end
            end else if (!busy_v[d]) begin
                check("idle_pwm", int'(pwm_v[d]), 0);
            end

            if (symb_v[d]) begin
                if (pend_n[d] > 0) begin
                    v = pend_buf[d][0];
                    for (int i = 0; i < 3; i++) pend_buf[d][i] = pend_buf[d][i + 1];
                    pend_n[d]--;
                end else if (d == 1 && have_last[d]) begin
                    v = last_val[d];
                    set_ev = 1'b1;
                end else begin
                    check("symb_without_data", 1, 0);
                    v = last_val[d];
                end
                sym_active[d] = 1'b1;
                sym_val[d]    = v;
                sym_len[d]    = 0;
                sym_high[d]   = 0;
                last_val[d]   = v;
                have_last[d]  = 1'b1;
                sym_count[d]++;
                sym_dist[d]      = cyc - last_symb_cyc[d];
                last_symb_cyc[d] = cyc;
            end
            if (sym_active[d] && enable) sym_len[d]++;

            exp_ur[d] = set_ev || (exp_ur[d] && !clr_prev);
            check("underrun", int'(underrun_v[d]), int'(exp_ur[d]));
            check("busy", int'(busy_v[d]), int'(sym_active[d]));

            if (pop_pv[d] && pend_n[d] < 4) begin
                pend_buf[d][pend_n[d]] = pop_val[d];
                pend_n[d]++;
            end
        end
        busy_prev[d] = busy_v[d];

        if (!enable || rst) check("read_gated", int'(read_v[d]), 0);
        pop_pv[d]  = read_v[d];
        pop_val[d] = int'(sample_a[d]);
        if (read_v[d]) rd_count[d]++;
    endtask

    // One clock: apply pops and new inputs after the edge, observe mid-cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        en_prev  = enable;
        rst_prev = rst;
        clr_prev = clr_underrun;
        for (int d = 0; d < 2; d++) begin
            if (pop_pv[d] && fifo_n[d] > 0) begin
                for (int i = 0; i < 15; i++) fifo_buf[d][i] = fifo_buf[d][i + 1];
                fifo_n[d]--;
            end
        end
        rst          = nx_rst;
        enable       = nx_enable;
        clr_underrun = nx_clr;
        def_empty    = nx_def_empty;
        for (int d = 0; d < 2; d++) begin
            if (fifo_n[d] > 0) begin
                empty_v[d]  = 1'b0;
                sample_a[d] = W'(fifo_buf[d][0]);
            end else begin
                empty_v[d]  = 1'b1;
                sample_a[d] = W'($urandom_range(0, 15));
            end
        end
        @(negedge clk);
        monitor(0);
        monitor(1);
    endtask

    task automatic wait_symb(input int d, input int budget);
        int start;
        int n;
        start = sym_count[d];
        n = 0;
        while (sym_count[d] == start && n < budget) begin
            cycle();
            n++;
        end
        check("symb_timeout", int'(sym_count[d] == start), 0);
    endtask

    initial begin
        int frozen;
        int rd0;
        int high;
        int n;

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst          = 1'b1;
        enable       = 1'b0;
        clr_underrun = 1'b0;
        def_sample   = 8'hFF;
        def_empty    = 1'b1;
        empty_v      = 2'b11;
        sample_a[0]  = '0;
        sample_a[1]  = '0;
        nx_rst       = 1'b1;
        nx_enable    = 1'b0;
        nx_clr       = 1'b0;
        nx_def_empty = 1'b1;
        for (int d = 0; d < 2; d++) begin
            fifo_n[d] = 0; pend_n[d] = 0; sym_count[d] = 0; rd_count[d] = 0;
            last_symb_cyc[d] = 0; sym_dist[d] = 0;
        end

        repeat (3) cycle();
        nx_rst    = 1'b0;
        nx_enable = 1'b1;
        cycle();

        // Single sample then empty: idle mode stops, repeat mode keeps going
        push(0, 5);
        push(1, 7);
        repeat (100) cycle();
        check("t1_idle_busy", int'(busy_v[0]), 0);
        check("t1_underrun", int'(underrun_v[0]), 1);
        check("t3_repeat_busy", int'(busy_v[1]), 1);
        check("t3_repeat_underrun", int'(underrun_v[1]), 1);
        nx_clr = 1'b1;
        cycle();
        nx_clr = 1'b0;
        cycle();
        check("t1_clr_underrun", int'(underrun_v[0]), 0);

        // Back-to-back samples, no gap between symbols
        rd0 = rd_count[0];
        push(0, 3); push(0, 15); push(0, 0);
        push(1, 3); push(1, 15); push(1, 0);
        wait_symb(0, 10);
        wait_symb(0, 40);
        check("t2_gap_1", sym_dist[0], SYM_LEN);
        wait_symb(0, 40);
        check("t2_gap_2", sym_dist[0], SYM_LEN);
        repeat (40) cycle();
        check("t2_reads", rd_count[0] - rd0, 3);

        // Freeze mid-symbol for 10 clocks
        push(0, 9); push(0, 4);
        wait_symb(0, 10);
        repeat (8) cycle();
        nx_enable = 1'b0;
        cycle();
        frozen = int'(pwm_v[0]);
        check("t4_frozen_high", frozen, 1);
        repeat (9) begin
            cycle();
            check("t4_freeze_pwm", int'(pwm_v[0]), frozen);
        end
        nx_enable = 1'b1;
        wait_symb(0, 60);
        check("t4_stretch", sym_dist[0], SYM_LEN + 10);
        repeat (40) cycle();

        // Reset mid-symbol with the prefetch slot full
        push(0, 6); push(0, 10); push(0, 11);
        wait_symb(0, 10);
        repeat (5) cycle();
        nx_rst = 1'b1;
        cycle();
        nx_rst = 1'b0;
        cycle();
        check("t5_pwm", int'(pwm_v[0]), 0);
        check("t5_busy", int'(busy_v[0]), 0);
        wait_symb(0, 10);
        check("t5_reread_fifo_left", fifo_n[0], 0);
        repeat (40) cycle();

        // Randomized traffic with bursts, stalls and clears
        for (int i = 0; i < 2500; i++) begin
            nx_enable = ($urandom_range(0, 9) != 0);
            nx_clr    = ($urandom_range(0, 39) == 0);
            for (int d = 0; d < 2; d++) begin
                if (fifo_n[d] < 4 && $urandom_range(0, 2 + 20 * ((i / 500) % 2)) == 0) begin
                    push(d, $urandom_range(0, 15));
                end
            end
            cycle();
        end
        nx_enable = 1'b1;
        nx_clr    = 1'b0;

        // Default parameters, full-scale sample: constant high over 255 clocks
        nx_def_empty = 1'b0;
        n = 0;
        cycle();
        while (!def_symb && n < 20) begin
            cycle();
            n++;
        end
        check("t6_symb_seen", int'(def_symb), 1);
        high = 0;
        repeat (255) begin
            cycle();
            high += int'(def_pwm);
        end
        check("t6_high", high, 255);
        check("t6_next_symb", int'(def_symb), 1);
        $display("[TB] default instance symbol high=%0d of 255", high);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
